// File: rtl/alarm_pkg.sv
// alarm_pkg: shared alarm channel state encoding and default time word width
package alarm_pkg;

    localparam int DEFAULT_TIME_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RINGING,
        ST_SNOOZED
    } alarm_state_t;

endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one alarm's match edge detection plus its ring/snooze state machine
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int TIME_W        = DEFAULT_TIME_W,
    parameter int RING_CYCLES   = 60_000_000,
    parameter int SNOOZE_CYCLES = 300_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clock_mode,
    input  logic              dismiss,
    input  logic              snooze,
    input  logic [TIME_W-1:0] current_time,
    input  logic [TIME_W-1:0] alarm_time,
    output logic              active
);

    localparam int CNT_W = $clog2(RING_CYCLES > SNOOZE_CYCLES ? RING_CYCLES : SNOOZE_CYCLES);
    localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_CYCLES - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_CYCLES - 1);

    alarm_state_t     state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             match, match_prev, trigger;

    assign match   = current_time == alarm_time;
    assign trigger = match & ~match_prev & en & clock_mode;

    // State, shared ring/snooze down-counter and previous match flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            match_prev <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            match_prev <= match;
        end
    end

    // Next state: disable beats everything, then dismiss > snooze > trigger > timeout
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (!en || dismiss) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state_d = ST_RINGING;
                        cnt_d   = RING_LOAD;
                    end
                end
                ST_RINGING: begin
                    if (snooze) begin
                        state_d = ST_SNOOZED;
                        cnt_d   = SNOOZE_LOAD;
                    end else if (cnt == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
                ST_SNOOZED: begin
                    if (trigger || cnt == '0) begin
                        state_d = ST_RINGING;
                        cnt_d   = RING_LOAD;
                    end else begin
                        cnt_d = cnt - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Ringing flag decoded from the registered state
    always_comb begin
        active = state == ST_RINGING;
    end

endmodule

// File: rtl/multi_alarm_mode.sv
// multi_alarm_mode: button edge detection, edit/display routing and N alarm channels
module multi_alarm_mode
    import alarm_pkg::*;
#(
    parameter int N_ALARMS      = 4,
    parameter int TIME_W        = DEFAULT_TIME_W,
    parameter int RING_CYCLES   = 60_000_000,
    parameter int SNOOZE_CYCLES = 300_000_000,
    localparam int SEL_W        = $clog2(N_ALARMS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SEL_W-1:0]           sel,
    input  logic [1:0]                 in_edit_btns,
    input  logic                       dismiss_btn,
    input  logic                       snooze_btn,
    input  logic [N_ALARMS-1:0]        alarm_en,
    input  logic [TIME_W-1:0]          current_time,
    input  logic [N_ALARMS*TIME_W-1:0] alarm_times,
    output logic [1:0]                 clock_edit_btns,
    output logic [2*N_ALARMS-1:0]      alarm_edit_btns,
    output logic [TIME_W-1:0]          display_time,
    output logic [N_ALARMS-1:0]        alarm_active,
    output logic                       alarm
);

    logic [3:0]       btn_s, btn_q, pulse;
    logic [SEL_W-1:0] sel_eff;
    logic             clock_mode;

    // Two-stage button sampling so each press yields one pulse a cycle after it is seen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s <= '0;
            btn_q <= '0;
        end else begin
            btn_s <= {in_edit_btns, dismiss_btn, snooze_btn};
            btn_q <= btn_s;
        end
    end

    assign pulse      = btn_s & ~btn_q;
    assign sel_eff    = (int'(sel) > N_ALARMS) ? '0 : sel;
    assign clock_mode = sel_eff == '0;

    assign clock_edit_btns = clock_mode ? pulse[3:2] : 2'b00;
    assign display_time    = clock_mode ? current_time
                                        : alarm_times[(int'(sel_eff) - 1) * TIME_W +: TIME_W];
    assign alarm           = |alarm_active;

    for (genvar k = 0; k < N_ALARMS; k++) begin : g_ch
        assign alarm_edit_btns[2*k +: 2] = (int'(sel_eff) == k + 1) ? pulse[3:2] : 2'b00;

        alarm_channel #(
            .TIME_W       (TIME_W),
            .RING_CYCLES  (RING_CYCLES),
            .SNOOZE_CYCLES(SNOOZE_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .en          (alarm_en[k]),
            .clock_mode  (clock_mode),
            .dismiss     (pulse[1]),
            .snooze      (pulse[0]),
            .current_time(current_time),
            .alarm_time  (alarm_times[k*TIME_W +: TIME_W]),
            .active      (alarm_active[k])
        );
    end

endmodule

// File: tb/tb_multi_alarm_mode.sv
// tb_multi_alarm_mode: directed and random stimulus against a deadline-based reference model
module tb_multi_alarm_mode;

    localparam int N  = 4;
    localparam int TW = 20;
    localparam int R  = 8;
    localparam int S  = 16;
    localparam int SW = 3;
    localparam int IDLE = 0, RING = 1, SNZ = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [SW-1:0]   sel = '0;
    logic [1:0]      edit = '0;
    logic            dismiss = 1'b0, snooze = 1'b0;
    logic [N-1:0]    en = '0;
    logic [TW-1:0]   ctime = '0;
    logic [N*TW-1:0] atimes = '0;
    logic [1:0]      clock_edit_btns;
    logic [2*N-1:0]  alarm_edit_btns;
    logic [TW-1:0]   display_time;
    logic [N-1:0]    alarm_active;
    logic            alarm;

    always #5 clk = ~clk;

    multi_alarm_mode #(
        .N_ALARMS(N), .TIME_W(TW), .RING_CYCLES(R), .SNOOZE_CYCLES(S)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .in_edit_btns(edit),
        .dismiss_btn(dismiss), .snooze_btn(snooze), .alarm_en(en),
        .current_time(ctime), .alarm_times(atimes),
        .clock_edit_btns(clock_edit_btns), .alarm_edit_btns(alarm_edit_btns),
        .display_time(display_time), .alarm_active(alarm_active), .alarm(alarm)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mode[N];
    int end_c[N];
    bit pm[N];
    logic [3:0] h1, h2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit clk_mode();
        return sel == 0 || int'(sel) > N;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            mode[k] = IDLE;
            end_c[k] = 0;
            pm[k] = 0;
        end
        h1 = '0;
        h2 = '0;
    endtask

    task automatic model_step();
        logic [3:0] p;
        bit cm, m, trig;
        int nxt;
        p = h1 & ~h2;
        cm = clk_mode();
        nxt = cyc + 1;
        for (int k = 0; k < N; k++) begin
            m = ctime == atimes[k*TW +: TW];
            trig = m && !pm[k] && en[k] && cm;
            if (!en[k] || p[1]) mode[k] = IDLE;
            else if (mode[k] == RING) begin
                if (p[0]) begin mode[k] = SNZ; end_c[k] = nxt + S; end
                else if (nxt == end_c[k]) mode[k] = IDLE;
            end else if (trig || (mode[k] == SNZ && nxt == end_c[k])) begin
                mode[k] = RING;
                end_c[k] = nxt + R;
            end
            pm[k] = m;
        end
        h2 = h1;
        h1 = {edit, dismiss, snooze};
    endtask

    task automatic compare();
        logic [3:0] p;
        logic [N-1:0] ea;
        logic [2*N-1:0] ee;
        logic [TW-1:0] ed;
        p = h1 & ~h2;
        for (int k = 0; k < N; k++) ea[k] = mode[k] == RING;
        ee = '0;
        ed = ctime;
        if (!clk_mode()) begin
            ee[2*(int'(sel)-1) +: 2] = p[3:2];
            ed = atimes[(int'(sel)-1)*TW +: TW];
        end
        check("alarm_active", 32'(alarm_active), 32'(ea));
        check("alarm", 32'(alarm), 32'(|ea));
        check("clock_edit", 32'(clock_edit_btns), clk_mode() ? 32'(p[3:2]) : 32'd0);
        check("alarm_edit", 32'(alarm_edit_btns), 32'(ee));
        check("display", 32'(display_time), 32'(ed));
    endtask

    task automatic tick();
        #1 compare();
        @(posedge clk);
        if (reset) model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic press_dismiss();
        dismiss = 1; tick(); dismiss = 0; tick();
    endtask

    task automatic press_snooze();
        snooze = 1; tick(); snooze = 0; tick();
    endtask

    initial begin
        model_clear();
        atimes[0*TW +: TW] = 20'h20000;
        atimes[1*TW +: TW] = 20'h12300;
        atimes[2*TW +: TW] = 20'h15000;
        atimes[3*TW +: TW] = 20'h20000;
        @(negedge clk);
        #1 check("reset_alarm", 32'(alarm), 32'd0);
        run(3);
        reset = 1;
        en = 4'b0010;
        run(2);

        // ring, timeout and no re-trigger while held
        ctime = 20'h12300;
        tick();
        for (int i = 0; i < R; i++) begin #1 check("ring_ch1", 32'(alarm_active), 32'h2); tick(); end
        for (int i = 0; i < 12; i++) begin #1 check("held_no_retrig", 32'(alarm_active), 32'h0); tick(); end

        // snooze, re-ring, then dismiss during snooze
        ctime = 20'h0; tick();
        ctime = 20'h12300; tick();
        ctime = 20'h0; run(3);
        press_snooze();
        for (int i = 0; i < S; i++) begin #1 check("snooze_gap", 32'(alarm), 32'h0); tick(); end
        #1 check("re_ring", 32'(alarm), 32'h1);
        run(2);
        press_snooze();
        run(5);
        press_dismiss();
        for (int i = 0; i < 25; i++) begin #1 check("dismissed", 32'(alarm), 32'h0); tick(); end

        // edit-mode suppression and edit routing
        sel = 3'd2; ctime = 20'h12300;
        edit = 2'b10; tick();
        #1 check("edit_ch1", 32'(alarm_edit_btns), 32'h08);
        run(2);
        #1 check("edit_once", 32'(alarm_edit_btns), 32'h00);
        edit = 2'b00; run(3);
        #1 check("sel2_no_trig", 32'(alarm), 32'h0);
        sel = 3'd0; ctime = 20'h0;
        edit = 2'b01; tick();
        #1 check("clk_edit", 32'(clock_edit_btns), 32'h1);
        edit = 2'b00; run(2);
        sel = 3'd7;
        edit = 2'b11; tick();
        #1 check("sel7_clk_edit", 32'(clock_edit_btns), 32'h3);
        edit = 2'b00; run(2);
        sel = 3'd0;

        // simultaneous triggers, shared dismiss, dismiss+snooze together
        en = 4'b1001; ctime = 20'h20000; tick();
        #1 check("both_ring", 32'(alarm_active), 32'h9);
        dismiss = 1; tick(); dismiss = 0; tick();
        #1 check("dismiss_both", 32'(alarm_active), 32'h0);
        ctime = 20'h0; tick();
        ctime = 20'h20000; run(2);
        dismiss = 1; snooze = 1; tick(); dismiss = 0; snooze = 0; tick();
        #1 check("dis_snz_idle", 32'(alarm_active), 32'h0);
        run(S + 2);

        // disable mid-ring, then reset mid-snooze
        ctime = 20'h0; tick();
        ctime = 20'h20000; run(2);
        en = 4'b1000; tick();
        #1 check("disable_ch0", 32'(alarm_active), 32'h8);
        press_snooze();
        run(4);
        reset = 0; model_clear(); ctime = 20'h0;
        #1 check("reset_clear", 32'(alarm_active), 32'h0);
        run(3);
        reset = 1;
        for (int i = 0; i < 30; i++) begin #1 check("post_reset", 32'(alarm), 32'h0); tick(); end

        // randomized phase
        en = 4'b1111;
        for (int i = 0; i < 4000; i++) begin
            sel = ($urandom_range(7) == 0) ? SW'($urandom_range(7)) : '0;
            if ($urandom_range(3) == 0) edit = 2'($urandom_range(3));
            dismiss = $urandom_range(29) == 0;
            snooze = $urandom_range(14) == 0;
            if ($urandom_range(99) == 0) en[$urandom_range(N-1)] ^= 1'b1;
            if ($urandom_range(3) == 0)
                case ($urandom_range(2))
                    0: ctime = atimes[$urandom_range(N-1)*TW +: TW];
                    1: ctime = 20'h12300;
                    default: ctime = TW'($urandom_range(15));
                endcase
            if ($urandom_range(999) == 0) begin
                reset = 0; model_clear();
                run(2);
                reset = 1;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
